// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side bus of the load/store unit.
// The slave modport is the LSU view; master is the surrounding core + memory.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    output stall, rsp_valid, rsp_rdata, fault, fault_cause,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_ready, mem_rdata,
    input  stall, rsp_valid, rsp_rdata, fault, fault_cause,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store stage: validates the access, drives one word-aligned memory
// transaction with a ready/timeout handshake and returns extended load data or a fault.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StErr, StDone} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [7:0]  cnt_q;
  logic [1:0]  err_cause_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_be_q;
  logic        rsp_valid_q;
  logic        fault_q;
  logic [1:0]  fault_cause_q;
  logic [31:0] rsp_rdata_q;

  logic        illegal;
  logic        misaligned;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [31:0] ld_shifted;
  logic [31:0] ld_data;

  // Request decode, evaluated on the live request while idle.
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (bus.req_we) begin
      illegal = bus.req_funct3[2] | (bus.req_funct3[1:0] == 2'b11);
    end else begin
      illegal = (bus.req_funct3 == 3'b011) | (bus.req_funct3 == 3'b110) |
                (bus.req_funct3 == 3'b111);
    end
    misaligned = ((bus.req_funct3[1:0] == 2'b01) & bus.req_addr[0]) |
                 ((bus.req_funct3[1:0] == 2'b10) & (bus.req_addr[1:0] != 2'b00));
  end

  always_comb begin
    st_wdata = bus.req_wdata;
    st_be    = 4'b1111;
    case (bus.req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{bus.req_wdata[7:0]}};
        st_be    = 4'b0001 << bus.req_addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{bus.req_wdata[15:0]}};
        st_be    = 4'b0011 << bus.req_addr[1:0];
      end
      default: begin
        st_wdata = bus.req_wdata;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Words are always naturally aligned, so the shift is a no-op for LW.
  always_comb begin
    ld_shifted = bus.mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      3'b001:  ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      3'b100:  ld_data = {24'h0, ld_shifted[7:0]};
      3'b101:  ld_data = {16'h0, ld_shifted[15:0]};
      default: ld_data = ld_shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      cnt_q         <= 8'd0;
      err_cause_q   <= 2'b00;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      mem_be_q      <= 4'h0;
      rsp_valid_q   <= 1'b0;
      fault_q       <= 1'b0;
      fault_cause_q <= 2'b00;
      rsp_rdata_q   <= 32'h0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            off_q    <= bus.req_addr[1:0];
            if (illegal) begin
              state_q     <= StErr;
              err_cause_q <= 2'b10;
            end else if (misaligned) begin
              state_q     <= StErr;
              err_cause_q <= 2'b01;
            end else begin
              state_q     <= StReq;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_addr_q  <= {bus.req_addr[31:2], 2'b00};
              mem_wdata_q <= bus.req_we ? st_wdata : 32'h0;
              mem_be_q    <= bus.req_we ? st_be : 4'h0;
            end
          end
        end
        StReq: begin
          // Ready beats timeout when both land in the same cycle.
          if (bus.mem_ready) begin
            state_q       <= StDone;
            cnt_q         <= 8'd0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_wdata_q   <= 32'h0;
            mem_be_q      <= 4'h0;
            rsp_valid_q   <= 1'b1;
            fault_q       <= 1'b0;
            fault_cause_q <= 2'b00;
            rsp_rdata_q   <= we_q ? 32'h0 : ld_data;
          end else if (cnt_q == CntLast) begin
            state_q     <= StErr;
            err_cause_q <= 2'b11;
            cnt_q       <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 32'h0;
            mem_be_q    <= 4'h0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StErr: begin
          state_q       <= StDone;
          rsp_valid_q   <= 1'b1;
          fault_q       <= 1'b1;
          fault_cause_q <= err_cause_q;
          rsp_rdata_q   <= 32'h0;
        end
        StDone: begin
          state_q       <= StIdle;
          cnt_q         <= 8'd0;
          err_cause_q   <= 2'b00;
          rsp_valid_q   <= 1'b0;
          fault_q       <= 1'b0;
          fault_cause_q <= 2'b00;
        end
      endcase
    end
  end

  assign bus.stall       = bus.req_valid & (state_q != StDone);
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.fault       = fault_q;
  assign bus.fault_cause = fault_cause_q;
  assign bus.mem_req     = mem_req_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_be      = mem_be_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver, memory responder and response monitor
// run as separate processes against a transaction-level reference model.
module tb_load_store_unit;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit        we;
    bit [2:0]  f3;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] rdata;
    int        wt;
  } txn_t;

  typedef struct {
    bit [31:0] rdata;
    bit        fault;
    bit [1:0]  cause;
  } rsp_t;

  typedef struct {
    bit        we;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [3:0]  be;
    bit [31:0] rdata;
    int        wt;
    int        ncyc;
  } plan_t;

  rsp_t      exp_q[$];
  plan_t     plan_q[$];
  int        n_cmp = 0;
  int        n_err = 0;
  bit [31:0] last_rdata = 32'h0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: access rules expressed as byte arithmetic.
  function automatic void model(input txn_t t, output rsp_t r, output plan_t p,
                                output bit use_mem, output int lat);
    int     sz;
    int     o;
    bit     legal;
    longint v;
    sz      = 1 << t.f3[1:0];
    o       = int'(t.addr[1:0]);
    legal   = t.we ? (t.f3 inside {3'd0, 3'd1, 3'd2})
                   : (t.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    r       = '{rdata: 32'h0, fault: 1'b0, cause: 2'b00};
    p       = '{default: 0};
    use_mem = 1'b0;
    lat     = 2;
    if (!legal) begin
      r.fault = 1'b1;
      r.cause = 2'b10;
      return;
    end
    if ((o % sz) != 0) begin
      r.fault = 1'b1;
      r.cause = 2'b01;
      return;
    end
    use_mem = 1'b1;
    p.we    = t.we;
    p.addr  = t.addr & ~32'h3;
    p.rdata = t.rdata;
    p.wt    = t.wt;
    if (t.we) begin
      for (int i = 0; i < 4; i++) begin
        p.wdata[8*i+:8] = t.wdata[8*(i%sz)+:8];
        if (i >= o && i < o + sz) p.be[i] = 1'b1;
      end
    end
    if (t.wt >= int'(TIMEOUT)) begin
      p.ncyc  = int'(TIMEOUT);
      r.fault = 1'b1;
      r.cause = 2'b11;
      lat     = int'(TIMEOUT) + 2;
    end else begin
      p.ncyc = t.wt + 1;
      lat    = t.wt + 2;
      if (!t.we) begin
        v = longint'(t.rdata >> (8 * o)) & ((64'd1 << (8 * sz)) - 1);
        if (!t.f3[2] && sz < 4 && v[8*sz-1]) v = v - (64'sd1 << (8 * sz));
        r.rdata = v[31:0];
      end
    end
  endfunction

  function automatic txn_t mk(bit we, bit [2:0] f3, bit [31:0] addr, bit [31:0] wdata,
                              bit [31:0] rdata, int wt);
    txn_t t;
    t = '{we: we, f3: f3, addr: addr, wdata: wdata, rdata: rdata, wt: wt};
    return t;
  endfunction

  task automatic issue(input txn_t t);
    rsp_t  r;
    plan_t p;
    bit    um;
    int    lat;
    int    cyc;
    bit    got;
    model(t, r, p, um, lat);
    exp_q.push_back(r);
    if (um) plan_q.push_back(p);
    @(negedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = t.we;
    bus.req_funct3 = t.f3;
    bus.req_addr   = t.addr;
    bus.req_wdata  = t.wdata;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < int'(TIMEOUT) + 8) begin
      @(negedge clk);
      #1;
      cyc++;
      if (bus.rsp_valid) got = 1'b1;
      else chk("stall_busy", bus.stall, 1);
    end
    chk("latency", cyc, lat);
    chk("stall_done", bus.stall, 0);
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  // Load aborted by reset in its second REQ cycle; no response is expected.
  task automatic reset_abort();
    plan_t p;
    p = '{we: 1'b0, addr: 32'h40, wdata: 32'h0, be: 4'h0, rdata: 32'h0, wt: 10, ncyc: 2};
    plan_q.push_back(p);
    @(negedge clk);
    #1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h40;
    repeat (2) begin
      @(negedge clk);
      #1;
    end
    chk("abort_pre_mem_req", bus.mem_req, 1);
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("abort_mem_req", bus.mem_req, 0);
    chk("abort_stall", bus.stall, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    reset = 1'b0;
  endtask

  // Response monitor.
  always @(negedge clk) begin : monitor
    rsp_t e;
    if (reset) begin
      last_rdata = 32'h0;
    end else if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", bus.rsp_valid, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_fault", bus.fault, e.fault);
        chk("rsp_cause", bus.fault_cause, e.cause);
        last_rdata = e.rdata;
      end
    end else begin
      chk("rdata_hold", bus.rsp_rdata, last_rdata);
    end
  end

  // Memory responder: checks the bus against the planned transaction each cycle.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
  end

  always @(negedge clk) begin : memory
    plan_t cur;
    bit    active;
    int    n;
    if (bus.mem_req) begin
      if (!active) begin
        if (plan_q.size() == 0) begin
          chk("mem_req_unexpected", bus.mem_req, 0);
        end else begin
          cur    = plan_q.pop_front();
          active = 1'b1;
          n      = 0;
        end
      end
      if (active) begin
        n++;
        chk("mem_we", bus.mem_we, cur.we);
        chk("mem_addr", bus.mem_addr, cur.addr);
        chk("mem_be", bus.mem_be, cur.be);
        if (cur.we) chk("mem_wdata", bus.mem_wdata, cur.wdata);
        bus.mem_ready = (n == cur.wt + 1);
        bus.mem_rdata = bus.mem_ready ? cur.rdata : $urandom;
      end else begin
        bus.mem_ready = 1'b0;
      end
    end else begin
      if (active) begin
        chk("mem_req_cycles", n, cur.ncyc);
        active = 1'b0;
      end
      // Ready noise while idle must be ignored.
      bus.mem_ready = 1'($urandom_range(0, 1));
      bus.mem_rdata = $urandom;
    end
  end

  bit [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  bit [2:0] st_f3[3] = '{3'd0, 3'd1, 3'd2};

  initial begin
    txn_t t;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_stall", bus.stall, 0);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 0);
    chk("reset_fault", bus.fault, 0);
    chk("reset_cause", bus.fault_cause, 0);
    chk("reset_mem_req", bus.mem_req, 0);
    chk("reset_mem_we", bus.mem_we, 0);
    chk("reset_mem_addr", bus.mem_addr, 0);
    chk("reset_mem_wdata", bus.mem_wdata, 0);
    chk("reset_mem_be", bus.mem_be, 0);
    reset = 1'b0;

    issue(mk(1'b0, 3'b000, 32'h0000_0103, 32'h0, 32'h80AA_BBCC, 0));
    issue(mk(1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0, 3));
    issue(mk(1'b0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0));
    issue(mk(1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 0));
    issue(mk(1'b0, 3'b101, 32'h0000_0002, 32'h0, 32'hDEAD_BEEF, 1000));
    issue(mk(1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h1357_9BDF, int'(TIMEOUT) - 1));
    issue(mk(1'b1, 3'b100, 32'h0000_0020, 32'h5555_5555, 32'h0, 0));
    issue(mk(1'b1, 3'b000, 32'h0000_0033, 32'hCAFE_F00D, 32'h0, 1));
    reset_abort();
    issue(mk(1'b0, 3'b100, 32'h0000_0001, 32'h0, 32'h0000_F100, 0));

    for (int k = 0; k < 80; k++) begin
      t.we    = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) t.f3 = 3'($urandom);
      else if (t.we) t.f3 = st_f3[$urandom_range(0, 2)];
      else t.f3 = ld_f3[$urandom_range(0, 4)];
      t.addr  = $urandom;
      if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
      t.wdata = $urandom;
      t.rdata = $urandom;
      t.wt    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(14, 20))
                                            : int'($urandom_range(0, 3));
      issue(t);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    #1;
    chk("exp_q_drained", exp_q.size(), 0);
    chk("plan_q_drained", plan_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
